// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared helpers for the FIFO family.
//   clog2_depth : width needed to hold an occupancy value 0..depth.
//   next_ptr    : wrapping pointer advance for arbitrary (non power-of-2) depth.
// -----------------------------------------------------------------------------
package fifo_pkg;

    // Occupancy ranges over 0..depth inclusive, hence depth+1 values.
    function automatic int clog2_depth(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit compare-and-wrap; a mask would only be correct for powers of 2.
    function automatic int unsigned next_ptr(input int unsigned ptr,
                                             input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// -----------------------------------------------------------------------------
// fifo_ptr
//   Wrapping pointer counter, 0..DEPTH-1, used for both FIFO read and write
//   pointers.
//   clk_i  : clock, rising edge
//   rst_ni : synchronous active-low reset, clears ptr to 0
//   inc    : advance the pointer by one (wrapping) this cycle
//   ptr    : current pointer value
// -----------------------------------------------------------------------------
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       inc,
    output logic [$clog2(DEPTH)-1:0]   ptr
);

    localparam int PW = $clog2(DEPTH);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= PW'(next_ptr(32'(ptr), DEPTH));
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-word-fall-through FIFO with arbitrary depth, full
//   DEPTH-entry capacity, occupancy count and almost-full/almost-empty flags.
//   Optional sticky error flags are built when SYNC_FIFO_ERR_EN is defined;
//   otherwise overflow/underflow are constant 0.
//
//   clk_i        : clock, rising edge
//   rst_ni       : synchronous active-low reset (pointers, count, error flags)
//   push / in    : write request and data
//   pop          : read request, discards head entry
//   out          : head entry, 0 when empty
//   count        : occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty : decoded from count
//   overflow     : sticky, push that was not accepted
//   underflow    : sticky, pop while empty
// -----------------------------------------------------------------------------
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int DWIDTH    = 32,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int CWIDTH    = clog2_depth(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push,
    input  logic              pop,
    input  logic [DWIDTH-1:0] in,
    output logic [DWIDTH-1:0] out,
    output logic [CWIDTH-1:0] count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int PW = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     rptr;
    logic [PW-1:0]     wptr;
    logic              push_acc;
    logic              pop_acc;

    // Status is a pure decode of the count register so every flag moves on
    // the same edge as the push/pop that caused it.
    assign full         = (int'(count) == DEPTH);
    assign empty        = (count == '0);
    assign almost_full  = (int'(count) >= AFULL_TH);
    assign almost_empty = (int'(count) <= AEMPTY_TH);

    // A pop frees the slot the same cycle, so a full FIFO still takes a push
    // alongside an accepted pop. An empty FIFO never accepts a pop, even when
    // a push arrives together with it.
    assign pop_acc  = pop && !empty;
    assign push_acc = push && (!full || pop_acc);

    fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc    (pop_acc),
        .ptr    (rptr)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc    (push_acc),
        .ptr    (wptr)
    );

    // Storage carries no reset; stale contents are hidden by the empty mux.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push_acc) begin
            mem[wptr] <= in;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count <= '0;
        end else begin
            case ({push_acc, pop_acc})
                2'b10:   count <= count + CWIDTH'(1);
                2'b01:   count <= count - CWIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    assign out = empty ? '0 : mem[rptr];

`ifdef SYNC_FIFO_ERR_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && !push_acc) overflow  <= 1'b1;
            if (pop && empty)      underflow <= 1'b1;
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Two instances (DEPTH=5 and DEPTH=16) receive identical stimulus; each has
// its own queue scoreboard that is updated when stimulus is driven and
// compared against the DUT after every clock edge.
module tb_sync_fifo;

`ifdef SYNC_FIFO_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic       clk_i  = 1'b0;
    logic       rst_ni = 1'b0;
    logic       push   = 1'b0;
    logic       pop    = 1'b0;
    logic [7:0] din    = 8'h00;

    logic [7:0] out5, out16;
    logic [2:0] cnt5;
    logic [4:0] cnt16;
    logic       full5, empty5, af5, ae5, ov5, un5;
    logic       full16, empty16, af16, ae16, ov16, un16;

    int tests = 0;
    int fails = 0;

    logic [7:0] m5[$];
    logic [7:0] m16[$];
    logic       eov5 = 1'b0, eun5 = 1'b0, eov16 = 1'b0, eun16 = 1'b0;

    always #5 clk_i = ~clk_i;

    sync_fifo #(.DEPTH(5), .DWIDTH(8), .AFULL_TH(3), .AEMPTY_TH(2)) u5 (
        .clk_i(clk_i), .rst_ni(rst_ni), .push(push), .pop(pop), .in(din),
        .out(out5), .count(cnt5), .full(full5), .empty(empty5),
        .almost_full(af5), .almost_empty(ae5),
        .overflow(ov5), .underflow(un5)
    );

    sync_fifo #(.DEPTH(16), .DWIDTH(8), .AFULL_TH(14), .AEMPTY_TH(2)) u16 (
        .clk_i(clk_i), .rst_ni(rst_ni), .push(push), .pop(pop), .in(din),
        .out(out16), .count(cnt16), .full(full16), .empty(empty16),
        .almost_full(af16), .almost_empty(ae16),
        .overflow(ov16), .underflow(un16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int s5;
        int s16;
        s5  = m5.size();
        s16 = m16.size();
        chk("out5",   32'(out5),   (s5 != 0) ? 32'(m5[0]) : 32'h0);
        chk("cnt5",   32'(cnt5),   32'(s5));
        chk("full5",  32'(full5),  32'(s5 == 5));
        chk("empty5", 32'(empty5), 32'(s5 == 0));
        chk("af5",    32'(af5),    32'(s5 >= 3));
        chk("ae5",    32'(ae5),    32'(s5 <= 2));
        chk("ov5",    32'(ov5),    32'(eov5));
        chk("un5",    32'(un5),    32'(eun5));
        chk("out16",  32'(out16),  (s16 != 0) ? 32'(m16[0]) : 32'h0);
        chk("cnt16",  32'(cnt16),  32'(s16));
        chk("full16", 32'(full16), 32'(s16 == 16));
        chk("empty16",32'(empty16),32'(s16 == 0));
        chk("af16",   32'(af16),   32'(s16 >= 14));
        chk("ae16",   32'(ae16),   32'(s16 <= 2));
        chk("ov16",   32'(ov16),   32'(eov16));
        chk("un16",   32'(un16),   32'(eun16));
    endtask

    // One clock: drive inputs, advance the scoreboards, then compare #1 after
    // the edge.
    task automatic cyc(input logic p, input logic q, input logic [7:0] d,
                       input logic r = 1'b1);
        bit pa, wa;
        rst_ni = r;
        push   = p;
        pop    = q;
        din    = d;
        if (!r) begin
            m5.delete();
            m16.delete();
            eov5 = 1'b0; eun5 = 1'b0; eov16 = 1'b0; eun16 = 1'b0;
        end else begin
            pa = q && (m5.size() != 0);
            wa = p && (m5.size() != 5 || pa);
            if (ERR && p && !wa) eov5 = 1'b1;
            if (ERR && q && m5.size() == 0) eun5 = 1'b1;
            if (pa) void'(m5.pop_front());
            if (wa) m5.push_back(d);
            pa = q && (m16.size() != 0);
            wa = p && (m16.size() != 16 || pa);
            if (ERR && p && !wa) eov16 = 1'b1;
            if (ERR && q && m16.size() == 0) eun16 = 1'b1;
            if (pa) void'(m16.pop_front());
            if (wa) m16.push_back(d);
        end
        @(posedge clk_i);
        #1;
        push   = 1'b0;
        pop    = 1'b0;
        rst_ni = 1'b1;
        check_all();
    endtask

    initial begin
        // Reset with push held high: reset must win.
        cyc(1'b1, 1'b0, 8'hEE, 1'b0);
        cyc(1'b1, 1'b0, 8'hEE, 1'b0);
        chk("rst_empty", 32'(empty5), 32'h1);
        chk("rst_cnt",   32'(cnt5),   32'h0);

        // Fill DEPTH=5; head stays 0x11.
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 1'b0, 8'(i * 8'h11));
            chk("fill_out", 32'(out5), 32'h11);
            chk("fill_cnt", 32'(cnt5), 32'(i));
        end
        chk("fill_full", 32'(full5), 32'h1);

        // Full with push+pop: count stays, head advances, no overflow.
        cyc(1'b1, 1'b1, 8'h66);
        chk("fsim_out",  32'(out5),  32'h22);
        chk("fsim_cnt",  32'(cnt5),  32'h5);
        chk("fsim_ov",   32'(ov5),   32'h0);

        // Rejected push into full FIFO.
        cyc(1'b1, 1'b0, 8'h99);
        chk("ovf_out", 32'(out5), 32'h22);
        chk("ovf_ov",  32'(ov5),  32'(ERR));

        // Drain, then pop while empty.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h00);
        chk("drain_out",   32'(out5),   32'h0);
        chk("drain_empty", 32'(empty5), 32'h1);
        cyc(1'b0, 1'b1, 8'h00);
        chk("udf_un", 32'(un5), 32'(ERR));

        // Refill after wrap.
        cyc(1'b1, 1'b0, 8'hAA);
        cyc(1'b1, 1'b0, 8'hBB);
        chk("wrap_out", 32'(out5), 32'hAA);
        chk("wrap_cnt", 32'(cnt5), 32'h2);

        // Clear, then push+pop on empty: push wins, pop rejected.
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("clr_ov", 32'(ov5), 32'h0);
        cyc(1'b1, 1'b1, 8'h77);
        chk("esim_out", 32'(out5), 32'h77);
        chk("esim_cnt", 32'(cnt5), 32'h1);
        chk("esim_un",  32'(un5),  32'(ERR));

        // Thresholds on DEPTH=16: fill to full then drain.
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 8'(8'h30 + i));
        chk("thr_full16", 32'(full16), 32'h1);
        for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 8'h00);
        chk("thr_empty16", 32'(empty16), 32'h1);

        // Mid-operation reset at count 7 with push asserted.
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i));
        chk("mid_cnt7", 32'(cnt16), 32'h7);
        cyc(1'b1, 1'b0, 8'hFF, 1'b0);
        chk("mid_cnt", 32'(cnt16), 32'h0);
        chk("mid_out", 32'(out16), 32'h0);

        // Random traffic, alternating push-heavy and pop-heavy phases.
        for (int i = 0; i < 400; i++) begin
            bit heavy_push;
            heavy_push = ((i / 50) % 2) == 0;
            cyc(($urandom_range(0, 9) < (heavy_push ? 8 : 3)) ? 1'b1 : 1'b0,
                ($urandom_range(0, 9) < (heavy_push ? 3 : 8)) ? 1'b1 : 1'b0,
                8'($urandom_range(0, 255)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Synchronous single-clock FIFO with arbitrary (non-power-of-2) depth, true full capacity, first-word-fall-through output, occupancy count, programmable almost-full/almost-empty flags and optional sticky overflow/underflow error flags. It is the general-purpose buffer for the library: UART/SPI staging, bus bridge command queues, and any producer/consumer pair in one clock domain.

## Interface
- DEPTH, 16: number of entries; any integer ≥ 2.
- DWIDTH, 32: data width in bits; ≥ 1.
- AFULL_TH, DEPTH-2: almost_full asserted when count ≥ AFULL_TH; 1 ≤ AFULL_TH ≤ DEPTH.
- AEMPTY_TH, 2: almost_empty asserted when count ≤ AEMPTY_TH; 0 ≤ AEMPTY_TH < DEPTH.
- CWIDTH, $clog2(DEPTH+1): derived width of count; not overridden.
- clk_i  in  1  clock; one clock, all logic on rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- push  in  1  write request; in captured when accepted.
- pop  in  1  read request; head entry discarded when accepted.
- in  in  DWIDTH  write data.
- out  out  DWIDTH  head entry (FWFT); 0 when empty.
- count  out  CWIDTH  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AFULL_TH.
- almost_empty  out  1  count ≤ AEMPTY_TH.
- overflow  out  1  sticky: push while not accepted (see Configuration).
- underflow  out  1  sticky: pop while empty (see Configuration).

## Operation
- State: storage array mem[DEPTH], read pointer rptr, write pointer wptr (0..DEPTH-1), count register.
- pop_acc = pop && !empty.
- push_acc = push && (!full || pop_acc): push into a full FIFO succeeds when a pop is accepted the same cycle.
- Empty with push and pop together: pop rejected (underflow if enabled), push accepted; count 0→1.
- push_acc: mem[wptr] ← in; wptr advances. pop_acc: rptr advances.
- Pointer advance: p == DEPTH-1 → 0, else p+1. No power-of-2 masking.
- count: +1 on push_acc only, -1 on pop_acc only, unchanged on both or neither. Never leaves 0..DEPTH.
- out = empty ? 0 : mem[rptr], combinational from registered state. Head is valid whenever !empty; pop consumes it.
- full/empty/almost_* decoded combinationally from count only.
- Storage is not reset; only pointers, count and error flags reset.

## Timing
- Reset (rst_ni low at a clock edge): rptr=wptr=count=0. Outputs next cycle: out=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AFULL_TH==0 ? 1 : 0), i.e. 0 given legal range, overflow=underflow=0. Reset wins over push/pop in the same cycle; mid-operation reset discards all contents.
- Write-to-read latency: data pushed at edge N is on out and empty=0 after edge N (visible cycle N+1).
- Pop at edge N: next entry (or 0 if now empty) on out after edge N.
- Flags and count update on the same edge as the causing push/pop; no lag, no look-ahead.
- Full-capacity throughput: one push and one pop per cycle sustained, including at full and at count 1.

## Configuration
- SYNC_FIFO_ERR_EN defined: overflow sets on any cycle with push && !push_acc; underflow sets on pop && empty. Both sticky until reset. Rejected operations never alter state.
- Not defined: overflow and underflow tied to 0, no flag registers; rejected operations still ignored silently.

## Structure
- Package fifo_pkg: function clog2_depth for CWIDTH, and the pointer-advance wrap function next_ptr(ptr, depth) shared with future FIFO variants.
- Sub-module fifo_ptr (parameter DEPTH; ports clk_i, rst_ni, inc, ptr): wrapping pointer counter, instantiated for rptr and wptr.
- Storage inferred as a plain register array in sync_fifo; no vendor RAM primitive.

## Test plan
- Reset/fill: DEPTH=5, push 0x11..0x55 on 5 cycles -> count 1..5, full=1 after fifth, out=0x11 throughout; sixth push rejected, overflow=1 (ERR_EN), out still 0x11.
- Drain/wrap: from above, pop 5 times -> out 0x22,0x33,0x44,0x55, then 0 with empty=1; push 0xAA,0xBB after -> out 0xAA, confirms pointer wrap 4→0.
- Full simultaneous: DEPTH=5 full, push 0x66 + pop -> count stays 5, out 0x22, full=1, overflow stays 0.
- Empty simultaneous: empty, push 0x77 + pop -> count 1, out 0x77, underflow=1 (ERR_EN) / 0 (not defined).
- Thresholds: DEPTH=16, AFULL_TH=14, AEMPTY_TH=2 -> almost_empty drops at count 3, almost_full rises at count 14, both tracked on pop back down.
- Mid-op reset: count=7, assert rst_ni low with push=1 -> next cycle count=0, empty=1, out=0, error flags 0.
